// File: rtl/loss_pkg.sv
// Shared types for the content-loss datapath: pixel/tile types, default geometry
// and the tile packer FSM encoding.
package loss_pkg;
    localparam int DEFAULT_SIZE  = 64;
    localparam int DEFAULT_PIX_W = 16;

    typedef logic [DEFAULT_PIX_W-1:0] pixel_t;
    typedef pixel_t [DEFAULT_SIZE-1:0] tile_t;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } pack_state_t;
endpackage

// File: rtl/loss_tile_packer_if.sv
// Paired-pixel input stream and packed-tile output stream of the tile packer.
interface loss_tile_packer_if
    import loss_pkg::*;
#(
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int PIX_W = DEFAULT_PIX_W,
    parameter int CNT_W = $clog2(SIZE + 1)
);
    logic                        in_valid;
    logic                        in_ready;
    logic [PIX_W-1:0]            in_content;
    logic [PIX_W-1:0]            in_generated;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic [SIZE-1:0][PIX_W-1:0]  out_content;
    logic [SIZE-1:0][PIX_W-1:0]  out_generated;
    logic [CNT_W-1:0]            out_count;
    logic                        out_last;

    modport slave (
        input  in_valid, in_content, in_generated, in_last, out_ready,
        output in_ready, out_valid, out_content, out_generated, out_count, out_last
    );

    modport master (
        output in_valid, in_content, in_generated, in_last, out_ready,
        input  in_ready, out_valid, out_content, out_generated, out_count, out_last
    );
endinterface

// File: rtl/tile_out_reg.sv
// Output tile register: holds a tile under backpressure and zeroes lanes at or
// beyond the real lane count when a new tile is loaded.
module tile_out_reg
    import loss_pkg::*;
#(
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int PIX_W = DEFAULT_PIX_W,
    parameter int CNT_W = $clog2(SIZE + 1)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       i_load,
    input  logic                       i_ready,
    input  logic [SIZE-1:0][PIX_W-1:0] i_content,
    input  logic [SIZE-1:0][PIX_W-1:0] i_generated,
    input  logic [CNT_W-1:0]           i_count,
    input  logic                       i_last,
    output logic                       o_free,
    output logic                       o_valid,
    output logic [SIZE-1:0][PIX_W-1:0] o_content,
    output logic [SIZE-1:0][PIX_W-1:0] o_generated,
    output logic [CNT_W-1:0]           o_count,
    output logic                       o_last
);
    logic                       r_valid;
    logic [SIZE-1:0][PIX_W-1:0] r_content;
    logic [SIZE-1:0][PIX_W-1:0] r_generated;
    logic [CNT_W-1:0]           r_count;
    logic                       r_last;
    logic [SIZE-1:0][PIX_W-1:0] w_pad_content;
    logic [SIZE-1:0][PIX_W-1:0] w_pad_generated;

    // Pad lanes read as zero so they add nothing to the squared distance.
    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_pad
            localparam logic [CNT_W-1:0] LANE = CNT_W'(gi);
            assign w_pad_content[gi]   = (LANE < i_count) ? i_content[gi]   : '0;
            assign w_pad_generated[gi] = (LANE < i_count) ? i_generated[gi] : '0;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid     <= 1'b0;
            r_content   <= '0;
            r_generated <= '0;
            r_count     <= '0;
            r_last      <= 1'b0;
        end else if (i_load) begin
            r_valid     <= 1'b1;
            r_content   <= w_pad_content;
            r_generated <= w_pad_generated;
            r_count     <= i_count;
            r_last      <= i_last;
        end else if (i_ready) begin
            r_valid     <= 1'b0;
        end
    end

    assign o_free      = !r_valid || i_ready;
    assign o_valid     = r_valid;
    assign o_content   = r_content;
    assign o_generated = r_generated;
    assign o_count     = r_count;
    assign o_last      = r_last;
endmodule

// File: rtl/loss_tile_packer.sv
// Deserializes a content/generated pixel-pair stream into SIZE-lane tiles,
// closing a tile when full or on in_last, with zero padding of short tiles.
module loss_tile_packer
    import loss_pkg::*;
#(
    parameter int SIZE  = DEFAULT_SIZE,
    parameter int PIX_W = DEFAULT_PIX_W,
    parameter int CNT_W = $clog2(SIZE + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    loss_tile_packer_if.slave bus
);
    localparam int IDX_W = $clog2(SIZE);

    pack_state_t                r_state;
    pack_state_t                w_state_next;
    logic [IDX_W-1:0]           r_idx;
    logic [PIX_W-1:0]           r_buf_content   [SIZE];
    logic [PIX_W-1:0]           r_buf_generated [SIZE];
    logic [CNT_W-1:0]           r_hold_count;
    logic                       r_hold_last;

    logic                       w_in_ready;
    logic                       w_accept;
    logic                       w_close;
    logic                       w_load;
    logic                       w_out_free;
    logic [CNT_W-1:0]           w_beat_count;
    logic [CNT_W-1:0]           w_ld_count;
    logic                       w_ld_last;
    logic [SIZE-1:0][PIX_W-1:0] w_ld_content;
    logic [SIZE-1:0][PIX_W-1:0] w_ld_generated;

    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_close      = w_accept && ((r_idx == IDX_W'(SIZE - 1)) || bus.in_last);
    assign w_beat_count = CNT_W'(r_idx) + CNT_W'(1);

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_load       = 1'b0;
        case (r_state)
            FILL: begin
                w_in_ready = 1'b1;
                if (w_close) begin
                    if (w_out_free) w_load = 1'b1;
                    else            w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (w_out_free) begin
                    w_load       = 1'b1;
                    w_state_next = FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= FILL;
            r_idx        <= '0;
            r_hold_count <= '0;
            r_hold_last  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_close) begin
                r_idx        <= '0;
                r_hold_count <= w_beat_count;
                r_hold_last  <= bus.in_last;
            end else if (w_accept) begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end
    end

    // Pixel storage carries no reset; lanes past the count are masked on copy.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_buf_content[r_idx]   <= bus.in_content;
            r_buf_generated[r_idx] <= bus.in_generated;
        end
    end

    // A close straight from FILL bypasses the closing beat into its lane.
    generate
        for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
            logic w_bypass;
            assign w_bypass = (r_state == FILL) && (r_idx == IDX_W'(gi));
            assign w_ld_content[gi]   = w_bypass ? bus.in_content   : r_buf_content[gi];
            assign w_ld_generated[gi] = w_bypass ? bus.in_generated : r_buf_generated[gi];
        end
    endgenerate

    assign w_ld_count  = (r_state == HOLD) ? r_hold_count : w_beat_count;
    assign w_ld_last   = (r_state == HOLD) ? r_hold_last  : bus.in_last;
    assign bus.in_ready = w_in_ready;

    tile_out_reg #(
        .SIZE  (SIZE),
        .PIX_W (PIX_W),
        .CNT_W (CNT_W)
    ) u_out (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_ready     (bus.out_ready),
        .i_content   (w_ld_content),
        .i_generated (w_ld_generated),
        .i_count     (w_ld_count),
        .i_last      (w_ld_last),
        .o_free      (w_out_free),
        .o_valid     (bus.out_valid),
        .o_content   (bus.out_content),
        .o_generated (bus.out_generated),
        .o_count     (bus.out_count),
        .o_last      (bus.out_last)
    );
endmodule

// File: tb/tb_loss_tile_packer.sv
// Bench for loss_tile_packer: table-driven streams, hand-written backpressure,
// latency and reset sequences, and a randomized run against a chunking model.
module tb_loss_tile_packer;
    import loss_pkg::*;

    localparam int SIZE  = 64;
    localparam int PIX_W = 16;
    localparam int CNT_W = $clog2(SIZE + 1);

    typedef logic [SIZE-1:0][PIX_W-1:0] vec_t;
    typedef struct {
        vec_t c;
        vec_t g;
        int   count;
        bit   last;
    } tile_s;
    typedef struct {
        int n;
        int mode;
        bit last_end;
        bit gaps;
        int exp_tiles;
        int exp_count0;
        bit exp_last0;
    } vec_s;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    loss_tile_packer_if #(.SIZE(SIZE), .PIX_W(PIX_W), .CNT_W(CNT_W)) bus ();

    loss_tile_packer #(.SIZE(SIZE), .PIX_W(PIX_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int    checks = 0;
    int    errors = 0;
    tile_s exp_q[$];
    tile_s got_q[$];
    vec_t  part_c;
    vec_t  part_g;
    int    part_n = 0;
    int    stall_cnt = 0;
    bit    gaps_en = 0;
    int    ready_pct = 100;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_vec(input string name, input vec_t act, input vec_t req);
        int bad = -1;
        for (int i = 0; i < SIZE; i++)
            if (act[i] !== req[i] && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s lane %0d actual=%0h required=%0h", name, bad, act[bad], req[bad]);
        end
    endtask

    // Reference: beats chunked into groups of SIZE, or shorter when a frame ends.
    task automatic model_push(input logic [PIX_W-1:0] c, input logic [PIX_W-1:0] g, input bit last);
        tile_s t;
        part_c[part_n] = c;
        part_g[part_n] = g;
        part_n++;
        if (part_n == SIZE || last) begin
            t.c = part_c; t.g = part_g; t.count = part_n; t.last = last;
            exp_q.push_back(t);
            part_c = '0; part_g = '0; part_n = 0;
        end
    endtask

    task automatic model_reset();
        part_c = '0; part_g = '0; part_n = 0;
    endtask

    always @(posedge clk) begin
        #1;
        bus.out_ready = ($urandom_range(99, 0) < ready_pct);
    end

    // Monitor: tile handshakes, input stalls, and stability while backpressured.
    tile_s held;
    bit    hold_armed = 0;
    always @(negedge clk) begin
        if (reset_n && bus.out_valid && bus.out_ready)
            got_q.push_back('{bus.out_content, bus.out_generated, int'(bus.out_count), bus.out_last});
        if (reset_n && bus.in_valid && !bus.in_ready) stall_cnt++;
        if (reset_n && hold_armed) begin
            check("stable_valid", longint'(bus.out_valid), 1);
            check("stable_count", bus.out_count, held.count);
            check("stable_last", longint'(bus.out_last), longint'(held.last));
            check_vec("stable_content", bus.out_content, held.c);
            check_vec("stable_generated", bus.out_generated, held.g);
        end
        hold_armed = reset_n && bus.out_valid && !bus.out_ready;
        held = '{bus.out_content, bus.out_generated, int'(bus.out_count), bus.out_last};
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [PIX_W-1:0] c, input logic [PIX_W-1:0] g, input bit last);
        int guard = 0;
        bit acc = 0;
        if (gaps_en)
            while ($urandom_range(1, 0) == 1) begin
                bus.in_valid = 1'b0;
                sync();
            end
        bus.in_valid = 1'b1;
        bus.in_content = c;
        bus.in_generated = g;
        bus.in_last = last;
        while (!acc) begin
            @(negedge clk);
            acc = bus.in_ready;
            sync();
            guard++;
            if (!acc && guard > 2000) begin
                checks++; errors++;
                $display("FAIL beat_timeout actual=no_accept required=accept");
                break;
            end
        end
        if (acc) model_push(c, g, last);
        bus.in_valid = 1'b0;
    endtask

    task automatic mkdata(input int mode, input int k, output logic [PIX_W-1:0] c, output logic [PIX_W-1:0] g);
        case (mode)
            0:       begin c = PIX_W'(k); g = PIX_W'(2 * k); end
            1:       begin c = 16'h00FF;  g = 16'h0100;      end
            3:       begin c = 16'hAAAA;  g = 16'hAAAA;      end
            default: begin c = PIX_W'($urandom); g = PIX_W'($urandom); end
        endcase
    endtask

    task automatic stream(input int n, input int mode, input bit last_end);
        logic [PIX_W-1:0] c, g;
        for (int k = 0; k < n; k++) begin
            mkdata(mode, k, c, g);
            beat(c, g, last_end && (k == n - 1));
        end
    endtask

    task automatic wait_tiles(input int n, input int limit);
        int guard = 0;
        while (got_q.size() < n && guard < limit) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic drain(input string name);
        tile_s e, a;
        wait_tiles(exp_q.size(), 500);
        check({name, "_ntiles"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = got_q.pop_front();
            check({name, "_count"}, a.count, e.count);
            check({name, "_last"}, longint'(a.last), longint'(e.last));
            check_vec({name, "_content"}, a.c, e.c);
            check_vec({name, "_generated"}, a.g, e.g);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    vec_s vecs[7];

    initial begin
        vecs[0] = '{64,  0, 1'b0, 1'b0, 1, 64, 1'b0};
        vecs[1] = '{128, 0, 1'b0, 1'b0, 2, 64, 1'b0};
        vecs[2] = '{10,  1, 1'b1, 1'b0, 1, 10, 1'b1};
        vecs[3] = '{64,  2, 1'b1, 1'b0, 1, 64, 1'b1};
        vecs[4] = '{64,  0, 1'b0, 1'b1, 1, 64, 1'b0};
        vecs[5] = '{1,   2, 1'b1, 1'b0, 1, 1,  1'b1};
        vecs[6] = '{65,  2, 1'b1, 1'b0, 2, 64, 1'b0};

        bus.in_valid = 1'b0;
        bus.in_content = '0;
        bus.in_generated = '0;
        bus.in_last = 1'b0;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", longint'(bus.out_valid), 0);
        check("rst_out_count", bus.out_count, 0);
        check("rst_out_last", longint'(bus.out_last), 0);
        check_vec("rst_out_content", bus.out_content, '0);
        check_vec("rst_out_generated", bus.out_generated, '0);
        sync();
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", longint'(bus.in_ready), 1);
        sync();

        foreach (vecs[i]) begin
            stall_cnt = 0;
            gaps_en = vecs[i].gaps;
            stream(vecs[i].n, vecs[i].mode, vecs[i].last_end);
            gaps_en = 0;
            wait_tiles(vecs[i].exp_tiles, 200);
            check($sformatf("v%0d_ntiles", i), got_q.size(), vecs[i].exp_tiles);
            if (got_q.size() > 0) begin
                check($sformatf("v%0d_count0", i), got_q[0].count, vecs[i].exp_count0);
                check($sformatf("v%0d_last0", i), longint'(got_q[0].last), longint'(vecs[i].exp_last0));
            end
            check($sformatf("v%0d_stalls", i), stall_cnt, 0);
            drain($sformatf("v%0d", i));
            sync();
        end

        // Latency: out_valid rises in the cycle right after the closing beat.
        stream(63, 0, 1'b0);
        @(negedge clk);
        check("lat_pre_valid", longint'(bus.out_valid), 0);
        sync();
        beat(16'h003F, 16'h007E, 1'b0);
        @(negedge clk);
        check("lat_valid", longint'(bus.out_valid), 1);
        check("lat_count", bus.out_count, 64);
        drain("lat");

        // Backpressure: two tiles with the output stalled.
        ready_pct = 0;
        sync();
        stream(128, 0, 1'b0);
        @(negedge clk);
        check("bp_in_ready_low", longint'(bus.in_ready), 0);
        check("bp_valid", longint'(bus.out_valid), 1);
        check("bp_count", bus.out_count, 64);
        check("bp_lane1", bus.out_content[1], 1);
        repeat (4) @(negedge clk);
        ready_pct = 100;
        @(negedge clk);
        @(negedge clk);
        check("bp_second_valid", longint'(bus.out_valid), 1);
        check("bp_second_lane0", bus.out_content[0], 64);
        check("bp_in_ready_back", longint'(bus.in_ready), 1);
        drain("bp");
        sync();

        // Reset mid-tile discards the partial tile.
        stream(30, 2, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", longint'(bus.out_valid), 0);
        check("mid_rst_count", bus.out_count, 0);
        check("mid_rst_last", longint'(bus.out_last), 0);
        check_vec("mid_rst_content", bus.out_content, '0);
        check_vec("mid_rst_generated", bus.out_generated, '0);
        model_reset();
        sync();
        reset_n = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", longint'(bus.in_ready), 1);
        sync();
        stream(64, 3, 1'b0);
        drain("post_rst");
        sync();

        // Randomized frames with input gaps and output backpressure.
        gaps_en = 1;
        ready_pct = 70;
        for (int k = 0; k < 600; k++)
            beat(PIX_W'($urandom), PIX_W'($urandom), (k == 599) || ($urandom_range(15, 0) == 0));
        gaps_en = 0;
        @(negedge clk);
        ready_pct = 100;
        drain("rand");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/loss_tile_packer.md
Name: loss_tile_packer

Overview:
- Upstream feeder for the content-loss stage: deserializes a paired pixel stream (content + generated, one pair per beat from the DDR3 read path) into SIZE-lane packed tiles.
- Each tile is presented as two parallel vectors on a valid/ready output.
- Short final tiles are zero-padded in both vectors, so padded lanes contribute zero squared distance downstream.

Parameters:
- SIZE, 64, pixels per tile (lanes); must be >= 2.
- PIX_W, 16, bits per pixel.
- CNT_W, $clog2(SIZE+1), width of the lane-count output (7 at default).

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  beat valid.
- in_ready  output  1  beat accepted when in_valid && in_ready.
- in_content  input  PIX_W  content pixel.
- in_generated  input  PIX_W  generated pixel.
- in_last  input  1  last beat of frame; closes current tile.
- out_valid  output  1  packed tile valid.
- out_ready  input  1  downstream accepts tile when out_valid && out_ready.
- out_content  output  SIZE x PIX_W  packed content lanes, lane 0 = first beat.
- out_generated  output  SIZE x PIX_W  packed generated lanes.
- out_count  output  CNT_W  number of real (non-pad) lanes, 1..SIZE.
- out_last  output  1  tile closes a frame.

Behaviour:
- Storage:
  - Fill buffer: SIZE pairs, lane index idx (0..SIZE-1), last flag.
  - Output register: one tile plus out_count and out_last.
- FSM states: FILL, HOLD.
- FILL:
  - in_ready = 1.
  - Accepted beat writes lane idx, then idx++.
  - Tile closes on the beat with idx == SIZE-1 or in_last = 1.
- Tile close, output free (out_valid = 0, or out_valid && out_ready this cycle):
  - Fill buffer copies to the output register; out_valid = 1 next cycle.
  - idx <= 0; stay FILL.
  - Continuous streaming sustains 1 beat/cycle with no bubbles.
- Tile close, output busy: go to HOLD.
- HOLD:
  - in_ready = 0.
  - When the output frees (same rule as above), copy the tile, idx <= 0, return to FILL.
- Latency: closing beat accepted in cycle N -> out_valid high in cycle N+1, provided the output is free.
- Copy / padding:
  - Lanes >= count are driven to 0 in both vectors.
  - Stale fill-buffer contents never reach the output.
  - out_count = idx+1 of the closing beat.
  - out_last = in_last of the closing beat.
- Output stability: while out_valid && !out_ready, all out_* hold stable.
- in_last with idx == SIZE-1: a single full tile with out_last = 1. No empty trailing tile is generated.
- in_valid = 0: no state change; idx holds across gaps.
- Pixel arithmetic: none. Data passes bit-exact.
- Reset values (asynchronous, any time, including mid-tile or in HOLD):
  - state = FILL, idx = 0, in_ready = 1 after release.
  - out_valid = 0, out_content = 0, out_generated = 0, out_count = 0, out_last = 0.
  - The partial tile is discarded.

Decomposition:
- Shared package loss_pkg:
  - PIX_W, SIZE defaults.
  - typedef pixel_t (logic [PIX_W-1:0]).
  - typedef tile_t (pixel_t [SIZE-1:0]), also used for content_loss inputs.
  - FSM enum pack_state_t {FILL, HOLD}.
- Sub-module tile_out_reg: output register with valid/ready hold and zero-pad mask generation. Keeps the FSM/fill logic separate.

Test Plan:
- Stream 64 beats, content = k, generated = 2k (k = 0..63), out_ready = 1 -> one tile, lane k content = k, generated = 2k, out_count = 64, out_last = 0, out_valid rises the cycle after beat 63.
- Stream 128 beats back-to-back, out_ready = 1 -> in_ready never drops; two tiles, second tile lane 0 content = 64.
- Stream 10 beats (content = 0x00FF, generated = 0x0100), in_last on beat 10 -> out_count = 10, out_last = 1, lanes 10..63 = 0 in both vectors.
- out_ready = 0 while two tiles are streamed -> first tile held stable, in_ready = 0 after the 128th beat; raise out_ready -> first tile consumed, second presented next cycle, in_ready returns to 1.
- Assert reset_n low after 30 beats, then release and stream 64 beats of 0xAAAA -> outputs zero during reset; next tile contains only 0xAAAA, out_count = 64.
- Random in_valid gaps (50%) with 64 beats -> identical tile to the gap-free case.
